i2c_bit_engine: RTL

I2C_BIT_ENGINE -- requirements
Module: i2c_bit_engine

---
 rtl/i2c_pkg.sv | 73 +++++++
 rtl/i2c_sync2.sv | 24 ++
 rtl/i2c_bit_engine.sv | 109 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// i2c_pkg: command codes, phase and state encodings, and the per-phase line-drive table
// Revision 1.0
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_D = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_B    = 3'd2,
    ST_C    = 3'd3,
    ST_D    = 3'd4
  } state_e;

  function automatic state_e next_state(state_e s);
    case (s)
      ST_A:    return ST_B;
      ST_B:    return ST_C;
      ST_C:    return ST_D;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic phase_e phase_of(state_e s);
    case (s)
      ST_B:    return PH_B;
      ST_C:    return PH_C;
      ST_D:    return PH_D;
      default: return PH_A;
    endcase
  endfunction

  // Returns {scl_oen, sda_oen}; START phase A keeps SCL where the previous command left it
  function automatic logic [1:0] line_drive(cmd_e c, phase_e p, logic wb, logic scl_prev);
    logic [1:0] d;
    d = 2'b00;
    case (c)
      CMD_START: begin
        case (p)
          PH_A:    d = {scl_prev, 1'b0};
          PH_B:    d = 2'b00;
          PH_C:    d = 2'b01;
          default: d = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (p)
          PH_A:    d = 2'b11;
          PH_B:    d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      CMD_WRITE: d = {(p == PH_A) || (p == PH_D), ~wb};
      default:   d = {(p == PH_A) || (p == PH_D), 1'b0};
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_sync2.sv
`default_nettype none
// i2c_sync2: two-flop synchroniser for an open-drain bus line; resets to the idle-high level
// Revision 1.0
module i2c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bit_engine.sv
`default_nettype none
// i2c_bit_engine: I2C master bit sequencer; every command runs four SCL quarter-phases
// Revision 1.0
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV    = 125,
  parameter bit STRETCH_EN = 1'b1,
  parameter bit ARB_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       w_bit,
  output logic       done,
  output logic       r_bit,
  output logic       arb_lost,
  output logic       busy,
  input  logic       scl_in,
  output logic       scl_oen,
  input  logic       sda_in,
  output logic       sda_oen
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  // Our own SCL release needs two cycles to reach the synchroniser output, so a low
  // level is only treated as slave stretching once that latency has elapsed
  localparam logic [CNT_W-1:0] STRETCH_AT = CNT_W'((CLK_DIV > 2) ? 2 : CLK_DIV - 1);

  state_e           state;
  cmd_e             cmd_q;
  logic             wbit_q;
  logic [CNT_W-1:0] cnt;
  logic             ready_en;
  logic             scl_s;
  logic             sda_s;
  logic             at_last;
  logic             stretching;
  logic             lose;

  i2c_sync2 u_sync_scl (.clk(clk), .rst(rst), .d(scl_in), .q(scl_s));
  i2c_sync2 u_sync_sda (.clk(clk), .rst(rst), .d(sda_in), .q(sda_s));

  assign at_last    = (cnt == LAST);
  assign stretching = STRETCH_EN && (state == ST_B) && !scl_s && (cnt >= STRETCH_AT);
  // STOP is judged only once SDA has had a full phase C to settle after release
  assign lose = ARB_EN && !sda_s &&
                (((state == ST_C) && (cmd_q == CMD_WRITE) && wbit_q) ||
                 ((cmd_q == CMD_STOP) && (((state == ST_C) && at_last) || (state == ST_D))));

  assign cmd_ready = ready_en && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd_q    <= CMD_START;
      wbit_q   <= 1'b0;
      scl_oen  <= 1'b0;
      sda_oen  <= 1'b0;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      r_bit    <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_valid && cmd_ready) begin
          cmd_q  <= cmd_e'(cmd);
          wbit_q <= w_bit;
          state  <= ST_A;
          cnt    <= '0;
          {scl_oen, sda_oen} <= line_drive(cmd_e'(cmd), PH_A, w_bit, scl_oen);
        end
      end else if (lose) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        scl_oen  <= 1'b0;
        sda_oen  <= 1'b0;
        done     <= 1'b1;
        arb_lost <= 1'b1;
      end else if (!stretching) begin
        if (at_last) begin
          if ((state == ST_C) && (cmd_q == CMD_READ)) begin
            r_bit <= sda_s;
          end
          cnt <= '0;
          if (state == ST_D) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            state <= next_state(state);
            {scl_oen, sda_oen} <= line_drive(cmd_q, phase_of(next_state(state)), wbit_q, scl_oen);
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
